// File: rtl/mips32_dbg_pkg.sv
// mips32_dbg_pkg: shared FSM states, source selects and sizes for the mips32 dump unit
package mips32_dbg_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_HALT, READ, CAPTURE, SEND, TRAILER, DONE} state_t;
  localparam logic SRC_MEM = 1'b0;
  localparam logic SRC_REG = 1'b1;
  localparam int REG_ADDR_W = 5;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/mips32_dump_serializer.sv
// mips32_dump_serializer: 32-to-8 MSB-first shift register with byte index and XOR checksum (ports: clock/reset, clear, load/load_data, shift, byte_data, last, checksum)
module mips32_dump_serializer
  import mips32_dbg_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] load_data,
  output logic [7:0]  byte_data,
  output logic        last,
  output logic [7:0]  checksum
);
  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  logic [31:0] shreg;
  logic [IDX_W-1:0] idx;
  assign byte_data = shreg[31:24];
  assign last = idx == IDX_W'(BYTES_PER_WORD - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg <= '0;
      idx <= '0;
      checksum <= '0;
    end else begin
      if (load) begin
        shreg <= load_data;
        idx <= '0;
      end else if (shift) begin
        shreg <= {shreg[23:0], 8'h00};
        idx <= idx + 1'b1;
        checksum <= checksum ^ shreg[31:24];
      end
      if (clear) checksum <= '0;
    end
  end
endmodule

// File: rtl/mips32_dump_unit.sv
// mips32_dump_unit: after HALTED, reads a Mem/Reg window and streams it as bytes plus an XOR checksum (ports: clock/reset, start/src_sel/start_addr/word_cnt, halted, rd_* read port, out_* stream, busy, done)
module mips32_dump_unit
  import mips32_dbg_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              src_sel,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  input  logic              halted,
  output logic              rd_en,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  state_t state_q, state_d;
  logic sel_q;
  logic [ADDR_W-1:0] addr_q, rd_addr_q, next_addr;
  logic [CNT_W-1:0] cnt_q;
  logic [REG_ADDR_W-1:0] reg_next;
  logic [7:0] ser_byte, checksum;
  logic last, hs, word_done, take;
  assign hs = out_valid && out_ready;
  assign take = state_q == IDLE && start;
  assign word_done = state_q == SEND && hs && last;
  assign reg_next = addr_q[REG_ADDR_W-1:0] + 1'b1;
  // register-file addresses wrap at 32 rather than at the memory size
  assign next_addr = sel_q == SRC_REG ? {{(ADDR_W-REG_ADDR_W){1'b0}}, reg_next} : addr_q + 1'b1;
  assign rd_sel = sel_q;
  mips32_dump_serializer u_ser (
    .clock(clock),
    .reset(reset),
    .clear(take),
    .load(state_q == CAPTURE),
    .shift(state_q == SEND && out_ready),
    .load_data(rd_data),
    .byte_data(ser_byte),
    .last(last),
    .checksum(checksum)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = word_cnt == '0 ? TRAILER : WAIT_HALT;
      WAIT_HALT: if (halted) state_d = READ;
      READ:      state_d = CAPTURE;
      CAPTURE:   state_d = SEND;
      SEND:      if (word_done) state_d = cnt_q == CNT_W'(1) ? TRAILER : READ;
      TRAILER:   if (hs) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    rd_en = state_q == READ;
    rd_addr = state_q == READ ? addr_q : rd_addr_q;
    out_valid = state_q == SEND || state_q == TRAILER;
    out_data = state_q == SEND ? ser_byte : state_q == TRAILER ? checksum : 8'h00;
    busy = state_q != IDLE;
    done = state_q == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q <= SRC_MEM;
      addr_q <= '0;
      cnt_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        sel_q <= src_sel;
        addr_q <= src_sel == SRC_REG ? {{(ADDR_W-REG_ADDR_W){1'b0}}, start_addr[REG_ADDR_W-1:0]} : start_addr;
        cnt_q <= word_cnt;
      end
      if (state_q == READ) rd_addr_q <= addr_q;
      if (word_done) begin
        cnt_q <= cnt_q - 1'b1;
        addr_q <= next_addr;
      end
    end
  end
endmodule

// File: doc/mips32_dump_unit.md
Name: mips32_dump_unit

Overview:
- Read-side counterpart to the bench/loader path that writes Mem and Reg in mips32.
- Once the CPU asserts HALTED, it reads a window of data memory or the register file through a synchronous read port.
- Streams the words out as bytes over a valid/ready interface, then appends an XOR checksum byte.
- Sits beside mips32 and lets a host or bench read results without hierarchical peeks.

Parameters:
- ADDR_W, 10, word-address width of the memory read port; addresses wrap modulo 2^ADDR_W.
- CNT_W, 11, width of the word-count input.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
- src_sel  input  1  0 = data memory (Mem), 1 = register file (Reg); captured at start.
- start_addr  input  ADDR_W  first word address, captured at start; for Reg only bits [4:0] are used.
- word_cnt  input  CNT_W  number of words to dump, captured at start.
- halted  input  1  CPU HALTED flag.
- rd_en  output  1  read strobe to the Mem/Reg read mux.
- rd_sel  output  1  registered copy of src_sel that steers the mux.
- rd_addr  output  ADDR_W  read address.
- rd_data  input  32  read data, valid exactly one cycle after rd_en.
- out_valid  output  1  byte available.
- out_data  output  8  stream byte.
- out_ready  input  1  downstream accepts the byte when out_valid && out_ready.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters and checksum 0. Reset mid-dump aborts at once; no done pulse.
- Start with count 0: if start and word_cnt==0 in IDLE, go to TRAILER, emit checksum 0x00, then done.
- States and transitions:
  - IDLE: on start, capture src_sel, start_addr, word_cnt; clear checksum; go to WAIT_HALT.
  - WAIT_HALT: hold until halted==1, then go to READ. A halted level already high at start costs one cycle here. halted dropping later is ignored.
  - READ: rd_en=1 for exactly one cycle with rd_addr = current address; go to CAPTURE.
  - CAPTURE: latch rd_data into a 32-bit shift register, set byte index 0, go to SEND.
  - SEND: out_valid=1; out_data = shreg[31:24], so bytes go out big-endian (MSB first).
    - On each handshake: shift left 8 and XOR the byte into the checksum.
    - After the 4th handshake: decrement remaining count and increment address with wrap (2^ADDR_W−1 → 0; for Reg, 31 → 0).
    - If remaining count is now 0, go to TRAILER; otherwise go to READ.
  - TRAILER: out_valid=1, out_data = checksum. On handshake go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Minimum latency per word is 6 cycles (READ, CAPTURE, 4 SEND beats) when out_ready is held high.
- Backpressure: while out_valid && !out_ready, out_data and all internal state hold. out_valid never drops before its handshake.
- start outside IDLE is ignored; parameters captured at start do not change mid-dump.
- rd_en is never asserted outside READ; rd_addr holds its last value otherwise.
- Checksum is the XOR of every payload byte, excluding the trailer byte itself.

Decomposition:
- Shared package mips32_dbg_pkg:
  - state encoding: IDLE, WAIT_HALT, READ, CAPTURE, SEND, TRAILER, DONE;
  - SRC_MEM=0 and SRC_REG=1;
  - REG_ADDR_W=5 and BYTES_PER_WORD=4.
- One natural sub-module, mips32_dump_serializer: the 32-to-8 shift register with byte index, handshake hold and checksum accumulation. The FSM, address and count logic stay in the top.

Test Plan:
- CPU runs ADDI R1,R0,5; SW R1,0(R6) with R6=0x78; HLT. Dump Mem, start_addr=120, word_cnt=1, out_ready=1 -> bytes 00 00 00 05, then checksum 05, then done one cycle later. No bytes appear before halted=1.
- Reg dump with Reg[1]=5, Reg[2]=5, start_addr=1, word_cnt=2 -> 00 00 00 05 00 00 00 05, checksum 00. rd_sel=1 throughout.
- Mem[1023]=0x12345678, Mem[0]=0xA5A5A5A5, start_addr=1023, word_cnt=2 -> 12 34 56 78 A5 A5 A5 A5, checksum 0x08. rd_addr sequence 1023 then 0.
- Backpressure: out_ready toggled pseudo-randomly -> identical byte sequence; out_data stable whenever out_valid && !out_ready.
- word_cnt=0 -> only trailer byte 00, then done; rd_en never asserted.
- reset asserted during the 2nd SEND byte -> next cycle busy=0, out_valid=0, done never pulses. A fresh start then dumps correctly from byte 0.
